piso_shreg16b: RTL

- Word-serial transmitter for the 8-stage 16-bit serial-in shift register chain.
- Parallel-loads eight 16-bit words in one cycle, then emits them one word per accepted transfer under a valid/ready handshake.
- Emits the word destined for the last stage first, so a serial-in chain clocked on each transfer ends with A..H matching the loaded A..H.

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_frame_store.sv | 28 ++
 rtl/piso_shreg16b.sv | 111 +++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso_shreg16b word-serial transmitter.
package piso_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned CNT_W     = $clog2(DEPTH_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_frame_store.sv
// DEPTH x WIDTH frame storage; the lowest word is the last stage and drives the serial output.
module piso_frame_store #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   load,
  input  logic                   shift,
  input  logic [DEPTH*WIDTH-1:0] frame,
  output logic [WIDTH-1:0]       head
);

  logic [DEPTH*WIDTH-1:0] mem;

  // Shifting toward the last stage fills with zeros, so the head reads 0 once the frame is drained.
  always_ff @(posedge clk) begin
    if (clear)
      mem <= '0;
    else if (load)
      mem <= frame;
    else if (shift)
      mem <= mem >> WIDTH;
  end

  assign head = mem[WIDTH-1:0];

endmodule

// File: rtl/piso_shreg16b.sv
// Word-serial transmitter: parallel-loads a frame and emits it last-stage first under valid/ready.
// Optional Dout_last output is enabled by defining PISO_LAST_EN.
module piso_shreg16b
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  output logic             Load_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H,
  output logic [WIDTH-1:0] Dout,
  output logic             Dout_valid,
  input  logic             Dout_ready,
`ifdef PISO_LAST_EN
  output logic             Dout_last,
`endif
  output logic             Busy
);

  localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_t                 state;
  logic                   valid;
  logic [CW-1:0]          cnt;
  logic                   last_xfer;
  logic                   load_acc;
  logic [8*WIDTH-1:0]     in_bus;
  logic [DEPTH*WIDTH-1:0] frame;

  // H sits in the lowest word so it is the first to reach the head of the store.
  assign in_bus = {A, B, C, D, E, F, G, H};

  generate
    if (DEPTH <= 8) begin : g_trim
      assign frame = in_bus[DEPTH*WIDTH-1:0];
    end else begin : g_pad
      assign frame = {{((DEPTH-8)*WIDTH){1'b0}}, in_bus};
    end
  endgenerate

  assign last_xfer  = valid & Dout_ready & (cnt == LAST);
  assign Load_ready = ~Reset & ((state == IDLE) | last_xfer);
  assign load_acc   = Load & Load_ready;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_acc) begin
            state <= SHIFT;
            valid <= 1'b1;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (valid & Dout_ready) begin
            if (cnt == LAST) begin
              cnt <= '0;
              if (!load_acc) begin
                state <= IDLE;
                valid <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  piso_frame_store #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_store (
    .clk   (Clock),
    .clear (Reset),
    .load  (load_acc),
    .shift (valid & Dout_ready),
    .frame (frame),
    .head  (Dout)
  );

  assign Dout_valid = valid;
  assign Busy       = valid;

`ifdef PISO_LAST_EN
  assign Dout_last = valid & (cnt == LAST);
`endif

endmodule
